map9v3_seq_ctrl: RTL and testbench

//  Upstream/downstream controller wrapped around one map9v3 instance. Accepts 9-bit requests
//  on a valid/ready stream, drives map9v3 N[8:0] and start, and waits for map9v3 done.

---
 rtl/map9v3_seq_ctrl_if.sv | 24 ++
 rtl/map9v3_seq_ctrl.sv | 219 +++++++++++++++++++++
 tb/tb_map9v3_seq_ctrl.sv | 272 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/map9v3_seq_ctrl_if.sv
// Request/result stream bundle between the sequencing controller and its user.
interface map9v3_seq_ctrl_if;
  localparam int unsigned DATA_W = 9;

  logic              req_valid;
  logic              req_ready;
  logic [DATA_W-1:0] req_n;
  logic              res_valid;
  logic              res_ready;
  logic [DATA_W-1:0] res_dp;
  logic              res_err;

  // User side: issues requests, consumes results
  modport master (
    output req_valid, req_n, res_ready,
    input  req_ready, res_valid, res_dp, res_err
  );

  // Controller side
  modport slave (
    input  req_valid, req_n, res_ready,
    output req_ready, res_valid, res_dp, res_err
  );
endinterface

// File: rtl/map9v3_seq_ctrl.sv
// Sequencing controller for a single map9v3: launches one request at a time,
// waits for completion (with timeout) and queues results in a small FIFO.
module map9v3_seq_ctrl #(
  parameter int unsigned DEPTH       = 4,
  parameter int unsigned START_CYC   = 2,
  parameter int unsigned TIMEOUT_CYC = 1023
) (
  input  logic                     i_clock,
  input  logic                     i_reset,
  map9v3_seq_ctrl_if.slave         io_bus,
  output logic [8:0]               o_map_n,
  output logic                     o_map_start,
  input  logic                     i_map_done,
  input  logic [8:0]               i_map_dp,
  output logic                     o_busy,
  output logic [7:0]               o_timeout_cnt
);

  localparam int unsigned DW      = 9;
  localparam int unsigned CNT_W   = 10;
  localparam int unsigned PTR_W   = $clog2(DEPTH);
  localparam int unsigned FCNT_W  = $clog2(DEPTH + 1);

  typedef struct packed {
    logic          err;
    logic [DW-1:0] dp;
  } res_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_WAIT_CLR,
    S_WAIT_DONE
  } state_t;

  state_t             r_state;
  logic [CNT_W-1:0]   r_cnt;
  logic [DW-1:0]      r_map_n;
  logic               r_map_start;
  logic               r_busy;
  logic [7:0]         r_timeout_cnt;

  res_t               r_mem [DEPTH];
  logic [PTR_W-1:0]   r_wr_ptr;
  logic [PTR_W-1:0]   r_rd_ptr;
  logic [FCNT_W-1:0]  r_count;
  logic               r_res_valid;
  logic [DW-1:0]      r_res_dp;
  logic               r_res_err;

  logic               w_req_ready;
  logic               w_timeout;
  logic               w_push;
  res_t               w_push_data;
  logic               w_abort;
  logic               w_pop;
  logic [PTR_W-1:0]   w_rd_ptr_nxt;
  logic [FCNT_W-1:0]  w_count_nxt;
  res_t               w_head;

  // Accept only when idle with guaranteed FIFO space; held low during reset
  assign w_req_ready = (r_state == S_IDLE) && (r_count < FCNT_W'(DEPTH)) && !i_reset;
  assign w_timeout   = (r_cnt == CNT_W'(TIMEOUT_CYC));

  // Result push decision: completion wins over a coincident timeout
  always_comb begin
    w_push      = 1'b0;
    w_push_data = '0;
    case (r_state)
      S_WAIT_CLR: begin
        if (i_map_done && w_timeout) begin
          w_push          = 1'b1;
          w_push_data.err = 1'b1;
        end
      end
      S_WAIT_DONE: begin
        if (i_map_done) begin
          w_push         = 1'b1;
          w_push_data.dp = i_map_dp;
        end else if (w_timeout) begin
          w_push          = 1'b1;
          w_push_data.err = 1'b1;
        end
      end
      default: begin
        w_push = 1'b0;
      end
    endcase
  end

  assign w_abort = w_push && w_push_data.err;

  // Launch/wait sequencer with registered map9v3 drive and abort counter
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_state       <= S_IDLE;
      r_cnt         <= '0;
      r_map_n       <= '0;
      r_map_start   <= 1'b0;
      r_busy        <= 1'b0;
      r_timeout_cnt <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (io_bus.req_valid && w_req_ready) begin
            r_map_n     <= io_bus.req_n;
            r_map_start <= 1'b1;
            r_cnt       <= '0;
            r_busy      <= 1'b1;
            r_state     <= S_START;
          end
        end
        S_START: begin
          if (r_cnt == CNT_W'(START_CYC - 1)) begin
            r_map_start <= 1'b0;
            r_cnt       <= '0;
            r_state     <= S_WAIT_CLR;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        S_WAIT_CLR: begin
          if (!i_map_done) begin
            r_cnt   <= '0;
            r_state <= S_WAIT_DONE;
          end else if (w_push) begin
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        S_WAIT_DONE: begin
          if (w_push) begin
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
      if (w_abort && (r_timeout_cnt != 8'hFF)) begin
        r_timeout_cnt <= r_timeout_cnt + 8'd1;
      end
    end
  end

  assign w_pop        = r_res_valid && io_bus.res_ready;
  assign w_rd_ptr_nxt = w_pop ? (r_rd_ptr + PTR_W'(1)) : r_rd_ptr;

  // FIFO occupancy after this cycle's push/pop
  always_comb begin
    w_count_nxt = r_count;
    case ({w_push, w_pop})
      2'b10:   w_count_nxt = r_count + FCNT_W'(1);
      2'b01:   w_count_nxt = r_count - FCNT_W'(1);
      default: w_count_nxt = r_count;
    endcase
  end

  // Next head entry; bypass when the pushed entry becomes the only one
  always_comb begin
    w_head = r_mem[w_rd_ptr_nxt];
    if (w_push && (r_wr_ptr == w_rd_ptr_nxt)) begin
      w_head = w_push_data;
    end
  end

  // Result storage (no reset needed; validity tracked by pointers)
  always_ff @(posedge i_clock) begin
    if (w_push && !i_reset) begin
      r_mem[r_wr_ptr] <= w_push_data;
    end
  end

  // FIFO pointers, count and registered head presentation
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_res_valid <= 1'b0;
      r_res_dp    <= '0;
      r_res_err   <= 1'b0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      end
      r_rd_ptr    <= w_rd_ptr_nxt;
      r_count     <= w_count_nxt;
      r_res_valid <= (w_count_nxt != '0);
      if (w_count_nxt != '0) begin
        r_res_dp  <= w_head.dp;
        r_res_err <= w_head.err;
      end else begin
        r_res_dp  <= '0;
        r_res_err <= 1'b0;
      end
    end
  end

  // Space is checked before every launch, so a full-FIFO push is a design bug
  a_no_overflow: assert property (@(posedge i_clock) disable iff (i_reset)
    !(w_push && (r_count == FCNT_W'(DEPTH))));

  assign io_bus.req_ready = w_req_ready;
  assign io_bus.res_valid = r_res_valid;
  assign io_bus.res_dp    = r_res_dp;
  assign io_bus.res_err   = r_res_err;
  assign o_map_n          = r_map_n;
  assign o_map_start      = r_map_start;
  assign o_busy           = r_busy;
  assign o_timeout_cnt    = r_timeout_cnt;

endmodule

// File: tb/tb_map9v3_seq_ctrl.sv
// Bench for map9v3_seq_ctrl with a behavioural map9v3 stand-in (dp = ~N).
module tb_map9v3_seq_ctrl;
  localparam int unsigned TMO = 16;

  logic       clk = 1'b0;
  logic       rst;
  logic [8:0] map_n;
  logic       map_start;
  logic       map_done;
  logic [8:0] map_dp;
  logic       busy;
  logic [7:0] tcnt;

  always #5 clk = ~clk;

  map9v3_seq_ctrl_if bus_if ();

  map9v3_seq_ctrl #(
    .DEPTH       (4),
    .START_CYC   (2),
    .TIMEOUT_CYC (TMO)
  ) dut (
    .i_clock       (clk),
    .i_reset       (rst),
    .io_bus        (bus_if),
    .o_map_n       (map_n),
    .o_map_start   (map_start),
    .i_map_done    (map_done),
    .i_map_dp      (map_dp),
    .o_busy        (busy),
    .o_timeout_cnt (tcnt)
  );

  // map9v3 stand-in: start edge clears done, done rises stub_lat+1 cycles later
  logic       stub_done, stub_start_d, stub_run, stub_hang;
  logic [8:0] stub_dp, stub_n;
  int         stub_cnt, stub_lat;

  always @(posedge clk) begin
    if (rst) begin
      stub_done <= 1'b0; stub_dp <= '0; stub_start_d <= 1'b0;
      stub_run <= 1'b0; stub_cnt <= 0; stub_n <= '0;
    end else begin
      stub_start_d <= map_start;
      if (map_start && !stub_start_d) begin
        stub_done <= 1'b0; stub_run <= 1'b1; stub_cnt <= 0; stub_n <= map_n;
      end else if (stub_run) begin
        if (stub_hang) stub_run <= 1'b0;
        else if (stub_cnt == stub_lat) begin
          stub_done <= 1'b1; stub_dp <= ~stub_n; stub_run <= 1'b0;
        end else stub_cnt <= stub_cnt + 1;
      end
    end
  end
  assign map_done = stub_done;
  assign map_dp   = stub_dp;

  int n_cmp = 0;
  int n_bad = 0;
  logic [9:0] exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard monitor: every handshake consumes one expected {err,dp}
  always @(negedge clk) begin
    if (!rst && bus_if.res_valid && bus_if.res_ready) begin
      if (exp_q.size() == 0) begin
        chk("res_unexpected", 32'({bus_if.res_err, bus_if.res_dp}), 32'h400);
      end else begin
        chk("res_entry", 32'({bus_if.res_err, bus_if.res_dp}), 32'(exp_q.pop_front()));
      end
    end
  end

  // Start pulse width per launch
  int start_run = 0;
  always @(negedge clk) begin
    if (rst) start_run = 0;
    else if (map_start) start_run++;
    else if (start_run != 0) begin
      chk("start_pulse_len", 32'(start_run), 32'd2);
      start_run = 0;
    end
  end

  // map_N at completion must equal the value captured at launch
  always @(negedge clk) begin
    if (!rst && busy && !map_start && map_done) chk("map_n_held", 32'(map_n), 32'(stub_n));
  end

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Called at posedge+1; returns at posedge+1 after the accepting edge
  task automatic send(input logic [8:0] n, input logic [9:0] exp);
    bit ok;
    ok = 1'b0;
    bus_if.req_valid = 1'b1;
    bus_if.req_n     = n;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (bus_if.req_ready) begin
        ok = 1'b1;
        exp_q.push_back(exp);
        break;
      end
      @(posedge clk); #1;
    end
    if (ok) begin
      @(posedge clk); #1;
    end
    bus_if.req_valid = 1'b0;
    if (!ok) chk("req_accept_timeout", 32'(ok), 32'd1);
  endtask

  task automatic wait_idle(input string name);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (!busy) begin ok = 1'b1; break; end
    end
    @(posedge clk); #1;
    if (!ok) chk(name, 32'(ok), 32'd1);
  endtask

  task automatic wait_res_valid(input string name);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (bus_if.res_valid) begin ok = 1'b1; break; end
    end
    @(posedge clk); #1;
    if (!ok) chk(name, 32'(ok), 32'd1);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit found;
    rst = 1'b1; bus_if.req_valid = 1'b0; bus_if.req_n = '0; bus_if.res_ready = 1'b0;
    stub_hang = 1'b0; stub_lat = 5;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_req_ready", 32'(bus_if.req_ready), 32'd0);
    chk("rst_map_n",     32'(map_n), 32'd0);
    chk("rst_map_start", 32'(map_start), 32'd0);
    chk("rst_res_valid", 32'(bus_if.res_valid), 32'd0);
    chk("rst_res_dp",    32'(bus_if.res_dp), 32'd0);
    chk("rst_res_err",   32'(bus_if.res_err), 32'd0);
    chk("rst_busy",      32'(busy), 32'd0);
    chk("rst_tcnt",      32'(tcnt), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // T1 single request
    bus_if.res_ready = 1'b1;
    send(9'h0A5, {1'b0, 9'h15A});
    wait_idle("t1_idle");
    cycles(3);
    chk("t1_res_drained", 32'(bus_if.res_valid), 32'd0);
    chk("t1_map_n_idle",  32'(map_n), 32'h0A5);

    // T2 back-to-back into a stalled consumer
    bus_if.res_ready = 1'b0;
    send(9'h000, {1'b0, 9'h1FF});
    send(9'h1FF, {1'b0, 9'h000});
    send(9'h123, {1'b0, 9'h0DC});
    send(9'h0F0, {1'b0, 9'h10F});
    wait_idle("t2_idle");
    cycles(2);
    chk("t2_full_ready", 32'(bus_if.req_ready), 32'd0);
    chk("t2_res_valid",  32'(bus_if.res_valid), 32'd1);
    bus_if.res_ready = 1'b1;
    cycles(6);
    chk("t2_drained", 32'(bus_if.res_valid), 32'd0);
    send(9'h1E1, {1'b0, 9'h01E});
    wait_idle("t2_fifth_idle");
    cycles(3);

    // T3 timeout abort
    stub_hang = 1'b1;
    send(9'h155, {1'b1, 9'h000});
    wait_idle("t3_idle");
    cycles(2);
    chk("t3_timeout_cnt", 32'(tcnt), 32'd1);
    chk("t3_busy",        32'(busy), 32'd0);
    chk("t3_req_ready",   32'(bus_if.req_ready), 32'd1);
    stub_hang = 1'b0;
    send(9'h03C, {1'b0, 9'h1C3});
    wait_idle("t3_next_idle");
    cycles(3);

    // T4 push and pop in the same cycle
    bus_if.res_ready = 1'b0;
    send(9'h123, {1'b0, 9'h0DC});
    wait_res_valid("t4_first_valid");
    send(9'h0F0, {1'b0, 9'h10F});
    found = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (busy && !map_start && map_done) begin found = 1'b1; break; end
      @(posedge clk); #1;
    end
    chk("t4_done_seen", 32'(found), 32'd1);
    bus_if.res_ready = 1'b1;
    @(posedge clk); #1;
    bus_if.res_ready = 1'b0;
    chk("t4_count_kept",  32'(bus_if.res_valid), 32'd1);
    chk("t4_head_second", 32'({bus_if.res_err, bus_if.res_dp}), 32'h10F);
    bus_if.res_ready = 1'b1;
    cycles(3);
    chk("t4_drained", 32'(bus_if.res_valid), 32'd0);

    // T6 head stability under backpressure
    bus_if.res_ready = 1'b0;
    send(9'h0C3, {1'b0, 9'h13C});
    wait_res_valid("t6_valid");
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("t6_res_dp",  32'(bus_if.res_dp), 32'h13C);
      chk("t6_res_err", 32'(bus_if.res_err), 32'd0);
    end
    @(posedge clk); #1;
    bus_if.res_ready = 1'b1;
    cycles(3);

    // T5 reset while waiting, with one result still queued
    bus_if.res_ready = 1'b0;
    send(9'h00F, {1'b0, 9'h1F0});
    wait_res_valid("t5_first_valid");
    stub_lat = 20;
    send(9'h0AA, {1'b0, 9'h155});
    cycles(6);
    chk("t5_in_wait", 32'(busy), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    chk("t5_ready_in_reset", 32'(bus_if.req_ready), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    exp_q.delete();
    chk("t5_map_start", 32'(map_start), 32'd0);
    chk("t5_busy",      32'(busy), 32'd0);
    chk("t5_res_valid", 32'(bus_if.res_valid), 32'd0);
    chk("t5_res_dp",    32'(bus_if.res_dp), 32'd0);
    chk("t5_res_err",   32'(bus_if.res_err), 32'd0);
    chk("t5_tcnt",      32'(tcnt), 32'd0);
    chk("t5_map_n",     32'(map_n), 32'd0);
    stub_lat = 5;
    bus_if.res_ready = 1'b1;
    send(9'h1E1, {1'b0, 9'h01E});
    wait_idle("t5_fresh_idle");
    cycles(5);
    chk("t5_fresh_drained", 32'(bus_if.res_valid), 32'd0);
    chk("queue_empty", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
